// File: rtl/alu_station.sv
// alu_station: reservation station in front of one ALU functional unit.
//
// Holds dispatched ALU micro-ops in an age-ordered compacting queue (entry 0 oldest),
// captures operands from the wb0/wb1/mu writeback buses, and every cycle drives the
// oldest issuable entry combinationally onto sel_*. Operand values on sel_*val already
// include same-cycle writeback bypass.
//
// Optional feature: define ALU_STATION_EARLY_WAKEUP_EN to let wk0/wk1 execute-stage
// wakeups make an operand issuable (sel_*val_ready = 0 in that case). Undefined, the
// wk* ports are ignored.
//
// Ports:
//   clk, resetn (sync, active-low), flush       : clock, reset, discard all entries
//   disp_valid / disp_ready                      : dispatch handshake
//   disp_*                                       : micro-op fields, tags, operand values
//   wk0_*, wk1_*                                 : early wakeup from ALU0/ALU1 execute
//   wb0_*, wb1_*, mu_*                           : writeback buses (en, ROB tag, data)
//   sel_valid, sel_*                             : selected entry for fu_alu
module alu_station #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ROB_SIZE = 16,
   parameter int unsigned ROBW     = $clog2(ROB_SIZE),
   parameter int unsigned ALUOPW   = 5,
   parameter int unsigned CTRLW    = 8,
   parameter int unsigned CMPOPW   = 3,
   parameter int unsigned EXCODEW  = 5,
   parameter int unsigned PREDW    = 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               flush,
   input  logic               disp_valid,
   output logic               disp_ready,
   input  logic [31:0]        disp_PC,
   input  logic [31:0]        disp_inst,
   input  logic [31:0]        disp_predict_target,
   input  logic [ALUOPW-1:0]  disp_aluop,
   input  logic [CTRLW-1:0]   disp_ctrl,
   input  logic [CMPOPW-1:0]  disp_cmpop,
   input  logic [EXCODEW-1:0] disp_excode,
   input  logic [PREDW-1:0]   disp_predict,
   input  logic [ROBW-1:0]    disp_rsnum,
   input  logic [ROBW-1:0]    disp_rtnum,
   input  logic [ROBW-1:0]    disp_destnum,
   input  logic [31:0]        disp_rsval,
   input  logic [31:0]        disp_rtval,
   input  logic               disp_rs_ready,
   input  logic               disp_rt_ready,
   input  logic               wk0_en,
   input  logic [ROBW-1:0]    wk0_num,
   input  logic               wk1_en,
   input  logic [ROBW-1:0]    wk1_num,
   input  logic               wb0_en,
   input  logic [ROBW-1:0]    wb0_num,
   input  logic [31:0]        wb0_data,
   input  logic               wb1_en,
   input  logic [ROBW-1:0]    wb1_num,
   input  logic [31:0]        wb1_data,
   input  logic               mu_en,
   input  logic [ROBW-1:0]    mu_num,
   input  logic [31:0]        mu_data,
   output logic               sel_valid,
   output logic [31:0]        sel_PC,
   output logic [31:0]        sel_inst,
   output logic [ALUOPW-1:0]  sel_aluop,
   output logic [CTRLW-1:0]   sel_ctrl,
   output logic [CMPOPW-1:0]  sel_cmpop,
   output logic [EXCODEW-1:0] sel_excode,
   output logic [PREDW-1:0]   sel_predict,
   output logic [31:0]        sel_predict_target,
   output logic [ROBW-1:0]    sel_rsnum,
   output logic [ROBW-1:0]    sel_rtnum,
   output logic [ROBW-1:0]    sel_destnum,
   output logic [31:0]        sel_rsval,
   output logic [31:0]        sel_rtval,
   output logic               sel_rsval_ready,
   output logic               sel_rtval_ready
);

   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic               valid;
      logic [31:0]        pc;
      logic [31:0]        inst;
      logic [31:0]        ptgt;
      logic [ALUOPW-1:0]  aluop;
      logic [CTRLW-1:0]   ctrl;
      logic [CMPOPW-1:0]  cmpop;
      logic [EXCODEW-1:0] excode;
      logic [PREDW-1:0]   predict;
      logic [ROBW-1:0]    rsnum;
      logic [ROBW-1:0]    rtnum;
      logic [ROBW-1:0]    destnum;
      logic               rs_rdy;
      logic               rt_rdy;
      logic [31:0]        rsval;
      logic [31:0]        rtval;
   } entry_t;

   entry_t          r_ent [DEPTH];
   logic [CntW-1:0] r_count;

   entry_t          w_upd [DEPTH];   // entries with this cycle's captures applied
   entry_t          w_nxt [DEPTH];
   entry_t          w_disp_ent;
   logic [32:0]     w_rs_bus [DEPTH];
   logic [32:0]     w_rt_bus [DEPTH];
   logic [32:0]     w_disp_rs_bus;
   logic [32:0]     w_disp_rt_bus;
   logic [DEPTH-1:0] w_rs_iss;
   logic [DEPTH-1:0] w_rt_iss;
   logic [DEPTH-1:0] w_issuable;
   logic [IdxW-1:0] w_sel_idx;
   logic            w_pop;
   logic            w_push;
   logic [CntW-1:0] w_wpos;

   // {hit, data} for a tag against the writeback buses; wb0 > wb1 > mu.
   function automatic logic [32:0] bus_lookup(input logic [ROBW-1:0] tag);
      if (wb0_en && wb0_num == tag) return {1'b1, wb0_data};
      if (wb1_en && wb1_num == tag) return {1'b1, wb1_data};
      if (mu_en && mu_num == tag)   return {1'b1, mu_data};
      return '0;
   endfunction

`ifdef ALU_STATION_EARLY_WAKEUP_EN
   function automatic logic wk_hit(input logic [ROBW-1:0] tag);
      return (wk0_en && wk0_num == tag) || (wk1_en && wk1_num == tag);
   endfunction
`else
   logic w_unused_wk;
   assign w_unused_wk = ^{wk0_en, wk0_num, wk1_en, wk1_num};
`endif

   assign disp_ready = (r_count != CntW'(DEPTH));
   assign w_push     = disp_valid & disp_ready & ~flush;
   assign w_pop      = sel_valid;
   assign w_wpos     = r_count - CntW'(w_pop);

   // Capture and issuability per entry
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_rs_bus[i] = bus_lookup(r_ent[i].rsnum);
         w_rt_bus[i] = bus_lookup(r_ent[i].rtnum);
         w_upd[i]    = r_ent[i];
         if (!r_ent[i].rs_rdy && w_rs_bus[i][32]) begin
            w_upd[i].rs_rdy = 1'b1;
            w_upd[i].rsval  = w_rs_bus[i][31:0];
         end
         if (!r_ent[i].rt_rdy && w_rt_bus[i][32]) begin
            w_upd[i].rt_rdy = 1'b1;
            w_upd[i].rtval  = w_rt_bus[i][31:0];
         end
`ifdef ALU_STATION_EARLY_WAKEUP_EN
         w_rs_iss[i] = w_upd[i].rs_rdy | wk_hit(r_ent[i].rsnum);
         w_rt_iss[i] = w_upd[i].rt_rdy | wk_hit(r_ent[i].rtnum);
`else
         w_rs_iss[i] = w_upd[i].rs_rdy;
         w_rt_iss[i] = w_upd[i].rt_rdy;
`endif
         w_issuable[i] = r_ent[i].valid & w_rs_iss[i] & w_rt_iss[i];
      end
   end

   // Oldest issuable entry wins
   always_comb begin
      sel_valid = 1'b0;
      w_sel_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_issuable[i]) begin
            sel_valid = 1'b1;
            w_sel_idx = IdxW'(i);
         end
      end
   end

   always_comb begin
      sel_PC             = '0;
      sel_inst           = '0;
      sel_aluop          = '0;
      sel_ctrl           = '0;
      sel_cmpop          = '0;
      sel_excode         = '0;
      sel_predict        = '0;
      sel_predict_target = '0;
      sel_rsnum          = '0;
      sel_rtnum          = '0;
      sel_destnum        = '0;
      sel_rsval          = '0;
      sel_rtval          = '0;
      sel_rsval_ready    = 1'b0;
      sel_rtval_ready    = 1'b0;
      if (sel_valid) begin
         sel_PC             = w_upd[w_sel_idx].pc;
         sel_inst           = w_upd[w_sel_idx].inst;
         sel_aluop          = w_upd[w_sel_idx].aluop;
         sel_ctrl           = w_upd[w_sel_idx].ctrl;
         sel_cmpop          = w_upd[w_sel_idx].cmpop;
         sel_excode         = w_upd[w_sel_idx].excode;
         sel_predict        = w_upd[w_sel_idx].predict;
         sel_predict_target = w_upd[w_sel_idx].ptgt;
         sel_rsnum          = w_upd[w_sel_idx].rsnum;
         sel_rtnum          = w_upd[w_sel_idx].rtnum;
         sel_destnum        = w_upd[w_sel_idx].destnum;
         sel_rsval          = w_upd[w_sel_idx].rsval;
         sel_rtval          = w_upd[w_sel_idx].rtval;
         sel_rsval_ready    = w_upd[w_sel_idx].rs_rdy;
         sel_rtval_ready    = w_upd[w_sel_idx].rt_rdy;
      end
   end

   // Incoming op, with capture from buses active in the dispatch cycle
   always_comb begin
      w_disp_rs_bus      = bus_lookup(disp_rsnum);
      w_disp_rt_bus      = bus_lookup(disp_rtnum);
      w_disp_ent.valid   = 1'b1;
      w_disp_ent.pc      = disp_PC;
      w_disp_ent.inst    = disp_inst;
      w_disp_ent.ptgt    = disp_predict_target;
      w_disp_ent.aluop   = disp_aluop;
      w_disp_ent.ctrl    = disp_ctrl;
      w_disp_ent.cmpop   = disp_cmpop;
      w_disp_ent.excode  = disp_excode;
      w_disp_ent.predict = disp_predict;
      w_disp_ent.rsnum   = disp_rsnum;
      w_disp_ent.rtnum   = disp_rtnum;
      w_disp_ent.destnum = disp_destnum;
      w_disp_ent.rs_rdy  = disp_rs_ready | w_disp_rs_bus[32];
      w_disp_ent.rt_rdy  = disp_rt_ready | w_disp_rt_bus[32];
      w_disp_ent.rsval   = disp_rs_ready ? disp_rsval : w_disp_rs_bus[31:0];
      w_disp_ent.rtval   = disp_rt_ready ? disp_rtval : w_disp_rt_bus[31:0];
   end

   // Compaction: entries above the popped slot move down one; push lands at count - pop.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_nxt[i] = w_upd[i];
      end
      if (w_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (IdxW'(i) >= w_sel_idx) w_nxt[i] = w_upd[i + 1];
         end
         w_nxt[DEPTH-1] = '0;
      end
      if (w_push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CntW'(i) == w_wpos) w_nxt[i] = w_disp_ent;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      end else begin
         r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
         for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt[i];
      end
   end

endmodule
